instr_decode: RTL and testbench
===============================

# instr_decode

Single-cycle registered RV32I instruction decoder in the execution front end. It sits between instruction fetch and register read/execute. Each cycle it samples a 32-bit instruction word, classifies it into an internal 6-bit operation code, extracts register indices with validity flags, and produces a sign-extended 32-bit immediate. All outputs are registered.

## Interface
- No parameters.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `instr`  in  32  raw RV32I instruction word.
- `op`  out  6  internal operation code; 0 means invalid/unsupported.
- `rs1_v`  out  1  instruction reads rs1.
- `rs1`  out  5  rs1 index; 0 when `rs1_v`=0.
- `rs2_v`  out  1  instruction reads rs2.
- `rs2`  out  5  rs2 index; 0 when `rs2_v`=0.
- `rd`  out  5  destination index; 0 when there is no destination. rd=x0 passes through as 0.
- `imm_v`  out  1  instruction carries an immediate.
- `imm`  out  32  sign-extended immediate; 0 when `imm_v`=0.

## Operation
- Op codes, in decimal:
  - 1 LUI, 2 AUIPC, 3 JAL, 4 JALR.
  - 5–10: BEQ, BNE, BLT, BGE, BLTU, BGEU.
  - 11–15: LB, LH, LW, LBU, LHU.
  - 16–18: SB, SH, SW.
  - 19–27: ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI.
  - 28–37: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND.
  - 38 FENCE, 39 ECALL, 40 EBREAK.
- Decode uses opcode[6:0], funct3[14:12] and funct7[31:25]. Any unlisted opcode, funct3 or funct7 combination is invalid. This includes R-type funct7 other than 0x00/0x20, and SLLI/SRLI/SRAI with illegal funct7.
- Field usage by format:
  - R: rs1_v=1, rs2_v=1, rd, imm_v=0.
  - I (loads, ALU-imm, JALR): rs1_v=1, rd, imm_v=1.
  - S, B: rs1_v=1, rs2_v=1, rd=0, imm_v=1.
  - U, J: rd, imm_v=1, rs1_v=rs2_v=0.
  - FENCE/ECALL/EBREAK: all flags 0, rd=0, imm=0.
- Immediates:
  - I: sign-extend instr[31:20].
  - Shifts: zero-extended shamt instr[24:20].
  - S: {instr[31:25],instr[11:7]}, sign-extended.
  - B: {instr[31],instr[7],instr[30:25],instr[11:8],0}, sign-extended.
  - U: {instr[31:12],12'b0}.
  - J: {instr[31],instr[19:12],instr[20],instr[30:21],0}, sign-extended.
- Invalid instruction: op=0 and every other output 0.

## Timing
- Outputs update on the rising edge of `clk`. Latency is exactly 1 cycle from `instr` to outputs. There is no handshake; a new instruction is accepted every cycle.
- `rst`=1 at an edge clears every output to 0, regardless of `instr`. Reset overrides any in-flight decode.
- The first edge after deassertion decodes the current `instr`.
- Outputs hold until the next edge.

## Configuration
- `INSTR_DECODE_SYSTEM_EN` defined: FENCE (opcode 0x0F) decodes to op 38. ECALL (0x00000073) decodes to op 39. EBREAK (0x00100073) decodes to op 40.
- Undefined: those encodings decode as invalid (op=0, all outputs 0). All other decoding is identical in both builds.

## Test plan
- 0x3E808093, 0x4B008093, 0x57808093, 0x64008093, 0x70808093 (ADDI x1,x1,imm) on successive cycles -> op 0x13, rs1_v=1, rs1=1, rs2_v=0, rs2=0, rd=1, imm_v=1; imm = 1000, 1200, 1400, 1600, 1800 respectively, each one cycle later.
- 0xFFF00113 (ADDI x2,x0,-1) -> op 0x13, rs1=0, rd=2, imm=0xFFFFFFFF.
- 0x002081B3 (ADD x3,x1,x2) -> op 28, rs1_v=rs2_v=1, rs1=1, rs2=2, rd=3, imm_v=0, imm=0.
- 0x0020A423 (SW x2,8(x1)) -> op 18, rs1=1, rs2=2, rd=0, imm_v=1, imm=8.
- 0x123452B7 (LUI x5,0x12345) -> op 1, rd=5, rs1_v=rs2_v=0, imm=0x12345000.
- Invalid and reset cases:
  - 0x00000000 -> all outputs 0.
  - rst=1 while `instr`=0x3E808093 -> all outputs 0 at that edge.
  - 0x00000073 -> op 39 with the macro defined, op 0 without it.

Source files
------------

// File: rtl/instr_decode.sv
// instr_decode: single-cycle registered RV32I instruction decoder.
//
// Each rising edge samples a raw instruction word and produces a registered
// internal op code, source/destination register indices with validity flags
// and a sign-extended 32-bit immediate. An invalid or unsupported encoding
// produces op=0 with every other output 0. There is no handshake. A new word
// is accepted every cycle, and the latency is exactly one cycle.
//
// Build option:
//   INSTR_DECODE_SYSTEM_EN  when defined, FENCE (opcode 0x0F, funct3 0) decodes
//                           to op 38, ECALL (0x00000073) to op 39 and EBREAK
//                           (0x00100073) to op 40. When undefined, these
//                           encodings decode as invalid.
//
// Ports:
//   clk    in   1   rising-edge clock
//   rst    in   1   synchronous active-high reset; clears every output
//   instr  in  32   raw RV32I instruction word
//   op     out  6   internal operation code, 0 = invalid
//   rs1_v  out  1   instruction reads rs1
//   rs1    out  5   rs1 index (0 when rs1_v=0)
//   rs2_v  out  1   instruction reads rs2
//   rs2    out  5   rs2 index (0 when rs2_v=0)
//   rd     out  5   destination index (0 when there is no destination)
//   imm_v  out  1   instruction carries an immediate
//   imm    out 32   immediate (0 when imm_v=0)
module instr_decode (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  output logic [5:0]  op,
  output logic        rs1_v,
  output logic [4:0]  rs1,
  output logic        rs2_v,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic        imm_v,
  output logic [31:0] imm
);

  // Instruction format. It selects which fields are driven. SH is the
  // shift-immediate form of the I format, which uses a zero-extended shamt.
  typedef enum logic [2:0] {
    F_NONE, F_R, F_I, F_SH, F_S, F_B, F_U, F_J
  } fmt_t;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  logic [31:0] imm_i, imm_sh, imm_s, imm_b, imm_u, imm_j;

  assign imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign imm_sh = {27'b0, instr[24:20]};
  assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u  = {instr[31:12], 12'b0};
  assign imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  logic [5:0]  d_op;
  fmt_t        d_fmt;
  logic        d_rs1_v, d_rs2_v, d_imm_v;
  logic [4:0]  d_rs1, d_rs2, d_rd;
  logic [31:0] d_imm;

  // Classification. d_fmt may be set even when funct3 or funct7 turns out to
  // be illegal. In that case d_op stays 0, and the field stage below ignores
  // the format.
  always_comb begin
    d_op  = 6'd0;
    d_fmt = F_NONE;
    case (opcode)
      7'h37: begin d_op = 6'd1; d_fmt = F_U; end              // LUI
      7'h17: begin d_op = 6'd2; d_fmt = F_U; end              // AUIPC
      7'h6F: begin d_op = 6'd3; d_fmt = F_J; end              // JAL
      7'h67: begin                                            // JALR
        d_fmt = F_I;
        if (funct3 == 3'd0) d_op = 6'd4;
      end
      7'h63: begin                                            // branches
        d_fmt = F_B;
        case (funct3)
          3'd0:    d_op = 6'd5;
          3'd1:    d_op = 6'd6;
          3'd4:    d_op = 6'd7;
          3'd5:    d_op = 6'd8;
          3'd6:    d_op = 6'd9;
          3'd7:    d_op = 6'd10;
          default: d_op = 6'd0;
        endcase
      end
      7'h03: begin                                            // loads
        d_fmt = F_I;
        case (funct3)
          3'd0:    d_op = 6'd11;
          3'd1:    d_op = 6'd12;
          3'd2:    d_op = 6'd13;
          3'd4:    d_op = 6'd14;
          3'd5:    d_op = 6'd15;
          default: d_op = 6'd0;
        endcase
      end
      7'h23: begin                                            // stores
        d_fmt = F_S;
        case (funct3)
          3'd0:    d_op = 6'd16;
          3'd1:    d_op = 6'd17;
          3'd2:    d_op = 6'd18;
          default: d_op = 6'd0;
        endcase
      end
      7'h13: begin                                            // ALU immediate
        d_fmt = F_I;
        case (funct3)
          3'd0: d_op = 6'd19;
          3'd2: d_op = 6'd20;
          3'd3: d_op = 6'd21;
          3'd4: d_op = 6'd22;
          3'd6: d_op = 6'd23;
          3'd7: d_op = 6'd24;
          3'd1: begin
            d_fmt = F_SH;
            if (funct7 == 7'h00) d_op = 6'd25;
          end
          3'd5: begin
            d_fmt = F_SH;
            if (funct7 == 7'h00)      d_op = 6'd26;
            else if (funct7 == 7'h20) d_op = 6'd27;
          end
          default: d_op = 6'd0;
        endcase
      end
      7'h33: begin                                            // ALU register
        d_fmt = F_R;
        if (funct7 == 7'h00) begin
          case (funct3)
            3'd0:    d_op = 6'd28;
            3'd1:    d_op = 6'd30;
            3'd2:    d_op = 6'd31;
            3'd3:    d_op = 6'd32;
            3'd4:    d_op = 6'd33;
            3'd5:    d_op = 6'd34;
            3'd6:    d_op = 6'd36;
            default: d_op = 6'd37;
          endcase
        end else if (funct7 == 7'h20) begin
          if (funct3 == 3'd0)      d_op = 6'd29;
          else if (funct3 == 3'd5) d_op = 6'd35;
        end
      end
`ifdef INSTR_DECODE_SYSTEM_EN
      7'h0F: begin                                            // FENCE
        if (funct3 == 3'd0) d_op = 6'd38;
      end
      7'h73: begin                                            // ECALL / EBREAK
        if (instr == 32'h0000_0073)      d_op = 6'd39;
        else if (instr == 32'h0010_0073) d_op = 6'd40;
      end
`else
`endif
      default: d_op = 6'd0;
    endcase
  end

  // Field extraction. Any field that the format does not use stays 0. System
  // ops keep the F_NONE format, so all of their fields are 0.
  always_comb begin
    d_rs1_v = 1'b0;
    d_rs2_v = 1'b0;
    d_imm_v = 1'b0;
    d_rs1   = 5'd0;
    d_rs2   = 5'd0;
    d_rd    = 5'd0;
    d_imm   = 32'd0;
    if (d_op != 6'd0) begin
      case (d_fmt)
        F_R:  begin d_rs1_v = 1'b1; d_rs2_v = 1'b1; d_rd = instr[11:7]; end
        F_I:  begin d_rs1_v = 1'b1; d_rd = instr[11:7]; d_imm_v = 1'b1; d_imm = imm_i;  end
        F_SH: begin d_rs1_v = 1'b1; d_rd = instr[11:7]; d_imm_v = 1'b1; d_imm = imm_sh; end
        F_S:  begin d_rs1_v = 1'b1; d_rs2_v = 1'b1; d_imm_v = 1'b1; d_imm = imm_s; end
        F_B:  begin d_rs1_v = 1'b1; d_rs2_v = 1'b1; d_imm_v = 1'b1; d_imm = imm_b; end
        F_U:  begin d_rd = instr[11:7]; d_imm_v = 1'b1; d_imm = imm_u; end
        F_J:  begin d_rd = instr[11:7]; d_imm_v = 1'b1; d_imm = imm_j; end
        default: d_imm = 32'd0;
      endcase
      if (d_rs1_v) d_rs1 = instr[19:15];
      if (d_rs2_v) d_rs2 = instr[24:20];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op    <= 6'd0;
      rs1_v <= 1'b0;
      rs1   <= 5'd0;
      rs2_v <= 1'b0;
      rs2   <= 5'd0;
      rd    <= 5'd0;
      imm_v <= 1'b0;
      imm   <= 32'd0;
    end else begin
      op    <= d_op;
      rs1_v <= d_rs1_v;
      rs1   <= d_rs1;
      rs2_v <= d_rs2_v;
      rs2   <= d_rs2;
      rd    <= d_rd;
      imm_v <= d_imm_v;
      imm   <= d_imm;
    end
  end

endmodule

// File: tb/tb_instr_decode.sv
module tb_instr_decode;

  logic        clk;
  logic        rst;
  logic [31:0] instr;
  logic [5:0]  op;
  logic        rs1_v;
  logic [4:0]  rs1;
  logic        rs2_v;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic        imm_v;
  logic [31:0] imm;

  instr_decode dut (
    .clk   (clk),
    .rst   (rst),
    .instr (instr),
    .op    (op),
    .rs1_v (rs1_v),
    .rs1   (rs1),
    .rs2_v (rs2_v),
    .rs2   (rs2),
    .rd    (rd),
    .imm_v (imm_v),
    .imm   (imm)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed output record: {op, rs1_v, rs1, rs2_v, rs2, rd, imm_v, imm} = 56 bits
  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [55:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   n_pass;
  int   n_total;

`ifdef INSTR_DECODE_SYSTEM_EN
  localparam logic [5:0] FENCE_OP  = 6'd38;
  localparam logic [5:0] ECALL_OP  = 6'd39;
  localparam logic [5:0] EBREAK_OP = 6'd40;
`else
  localparam logic [5:0] FENCE_OP  = 6'd0;
  localparam logic [5:0] ECALL_OP  = 6'd0;
  localparam logic [5:0] EBREAK_OP = 6'd0;
`endif

  function automatic logic [55:0] mk(input logic [5:0] e_op, input logic e_rs1_v,
                                     input logic [4:0] e_rs1, input logic e_rs2_v,
                                     input logic [4:0] e_rs2, input logic [4:0] e_rd,
                                     input logic e_imm_v, input logic [31:0] e_imm);
    return {e_op, e_rs1_v, e_rs1, e_rs2_v, e_rs2, e_rd, e_imm_v, e_imm};
  endfunction

  task automatic add(input string name, input logic [31:0] w, input logic [55:0] e);
    vec_t v;
    v.name  = name;
    v.instr = w;
    v.exp   = e;
    vecs.push_back(v);
  endtask

  // Scoreboard compare
  task automatic check(input string name, input logic [55:0] e);
    logic [55:0] act;
    act = {op, rs1_v, rs1, rs2_v, rs2, rd, imm_v, imm};
    n_total++;
    if (act === e) n_pass++;
    else $display("FAIL %s: got op=%0d rs1_v=%0b rs1=%0d rs2_v=%0b rs2=%0d rd=%0d imm_v=%0b imm=%h, expected op=%0d rs1_v=%0b rs1=%0d rs2_v=%0b rs2=%0d rd=%0d imm_v=%0b imm=%h",
                  name, act[55:50], act[49], act[48:44], act[43], act[42:38], act[37:33], act[32], act[31:0],
                  e[55:50], e[49], e[48:44], e[43], e[42:38], e[37:33], e[32], e[31:0]);
  endtask

  // Driver: present a word, then sample 1 time unit after the edge
  task automatic step(input logic [31:0] w);
    instr = w;
    @(posedge clk);
    #1;
  endtask

  localparam logic [55:0] ZERO = 56'd0;

  initial begin
    n_pass  = 0;
    n_total = 0;

    add("addi_1000",  32'h3E808093, mk(6'd19, 1, 5'd1, 0, 5'd0, 5'd1, 1, 32'd1000));
    add("addi_1200",  32'h4B008093, mk(6'd19, 1, 5'd1, 0, 5'd0, 5'd1, 1, 32'd1200));
    add("addi_1400",  32'h57808093, mk(6'd19, 1, 5'd1, 0, 5'd0, 5'd1, 1, 32'd1400));
    add("addi_1600",  32'h64008093, mk(6'd19, 1, 5'd1, 0, 5'd0, 5'd1, 1, 32'd1600));
    add("addi_1800",  32'h70808093, mk(6'd19, 1, 5'd1, 0, 5'd0, 5'd1, 1, 32'd1800));
    add("addi_neg1",  32'hFFF00113, mk(6'd19, 1, 5'd0, 0, 5'd0, 5'd2, 1, 32'hFFFFFFFF));
    add("add",        32'h002081B3, mk(6'd28, 1, 5'd1, 1, 5'd2, 5'd3, 0, 32'd0));
    add("sub",        32'h402081B3, mk(6'd29, 1, 5'd1, 1, 5'd2, 5'd3, 0, 32'd0));
    add("r_bad_f7",   32'h022081B3, ZERO);
    add("sw",         32'h0020A423, mk(6'd18, 1, 5'd1, 1, 5'd2, 5'd0, 1, 32'd8));
    add("sb_neg1",    32'hFE530FA3, mk(6'd16, 1, 5'd6, 1, 5'd5, 5'd0, 1, 32'hFFFFFFFF));
    add("lui",        32'h123452B7, mk(6'd1,  0, 5'd0, 0, 5'd0, 5'd5, 1, 32'h12345000));
    add("auipc",      32'hFFFFF397, mk(6'd2,  0, 5'd0, 0, 5'd0, 5'd7, 1, 32'hFFFFF000));
    add("zero_word",  32'h00000000, ZERO);
    add("srai_3",     32'h4030D093, mk(6'd27, 1, 5'd1, 0, 5'd0, 5'd1, 1, 32'd3));
    add("srai_31",    32'h41F0D093, mk(6'd27, 1, 5'd1, 0, 5'd0, 5'd1, 1, 32'd31));
    add("slli_bad",   32'h40309093, ZERO);
    add("beq_m4",     32'hFE208EE3, mk(6'd5,  1, 5'd1, 1, 5'd2, 5'd0, 1, 32'hFFFFFFFC));
    add("jal_m2",     32'hFFFFF0EF, mk(6'd3,  0, 5'd0, 0, 5'd0, 5'd1, 1, 32'hFFFFFFFE));
    add("jal_x0_800", 32'h0010006F, mk(6'd3,  0, 5'd0, 0, 5'd0, 5'd0, 1, 32'h00000800));
    add("lw_m8",      32'hFF81A203, mk(6'd13, 1, 5'd3, 0, 5'd0, 5'd4, 1, 32'hFFFFFFF8));
    add("load_bad",   32'h0001B203, ZERO);
    add("jalr",       32'h004100E7, mk(6'd4,  1, 5'd2, 0, 5'd0, 5'd1, 1, 32'd4));
    add("jalr_bad",   32'h00009067, ZERO);
    add("fence",      32'h0FF0000F, mk(FENCE_OP,  0, 5'd0, 0, 5'd0, 5'd0, 0, 32'd0));
    add("ecall",      32'h00000073, mk(ECALL_OP,  0, 5'd0, 0, 5'd0, 5'd0, 0, 32'd0));
    add("ebreak",     32'h00100073, mk(EBREAK_OP, 0, 5'd0, 0, 5'd0, 5'd0, 0, 32'd0));

    // Reset with a valid word present must still clear the outputs
    rst = 1'b1;
    step(32'h3E808093);
    step(32'h3E808093);
    check("reset_clears", ZERO);

    // The first edge after deassertion decodes. Vectors run back to back.
    rst = 1'b0;
    foreach (vecs[i]) begin
      step(vecs[i].instr);
      check(vecs[i].name, vecs[i].exp);
    end

    // Reset overrides an in-flight decode
    step(32'h002081B3);
    check("pre_reset_add", mk(6'd28, 1, 5'd1, 1, 5'd2, 5'd3, 0, 32'd0));
    rst = 1'b1;
    step(32'h3E808093);
    check("reset_midstream", ZERO);
    rst = 1'b0;
    step(32'h3E808093);
    check("post_reset_first", mk(6'd19, 1, 5'd1, 0, 5'd0, 5'd1, 1, 32'd1000));

    // Outputs hold while the input changes between edges
    #2 instr = 32'h123452B7;
    @(negedge clk);
    check("hold_mid_cycle", mk(6'd19, 1, 5'd1, 0, 5'd0, 5'd1, 1, 32'd1000));
    @(posedge clk);
    #1;
    check("hold_then_lui", mk(6'd1, 0, 5'd0, 0, 5'd0, 5'd5, 1, 32'h12345000));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
